axi4_stream_pkt: RTL and testbench

- Synthesizable AXI4-Stream packetizer that sits directly upstream of the stream drain.
- Accepts an unframed sample stream, cuts it into packets of a configurable length and asserts TLAST on the final beat of each packet.
- Limits the number of packets per run and provides start/stop control and status.
- Output is registered through a 2-entry skid buffer, so the consumer may apply arbitrary TREADY back-pressure.

---
 rtl/axi4_stream_pkt_if.sv | 15 +
 rtl/axi4_stream_pkt.sv | 146 ++++++++++++++
 tb/tb_axi4_stream_pkt.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_stream_pkt_if.sv
// AXI4-Stream bundle used on both sides of the packetizer.
// The master drives data/keep/last/valid and the slave returns ready.
interface axi4_stream_pkt_if #(
    parameter int DN = 1,
    parameter int DW = 8
);
    logic [DN*DW-1:0] TDATA;
    logic [DN-1:0]    TKEEP;
    logic             TLAST;
    logic             TVALID;
    logic             TREADY;

    modport master (output TDATA, output TKEEP, output TLAST, output TVALID, input TREADY);
    modport slave  (input TDATA, input TKEEP, input TLAST, input TVALID, output TREADY);
endinterface

// File: rtl/axi4_stream_pkt.sv
// Packetizer: frames an unframed stream into packets of cfg_len+1 beats with TLAST,
// bounds packets per run, and drives the output through a 2-entry skid buffer.
module axi4_stream_pkt #(
    parameter int DN = 1,
    parameter int DW = 8,
    parameter int LW = 16
) (
    input  logic                ACLK,
    input  logic                ARESET,
    axi4_stream_pkt_if.slave    s,
    axi4_stream_pkt_if.master   m,
    input  logic [LW-1:0]       cfg_len,
    input  logic [LW-1:0]       cfg_num,
    input  logic                ctl_start,
    input  logic                ctl_stop,
    output logic                sts_busy,
    output logic [LW-1:0]       sts_pkt
);
    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    typedef struct packed {
        logic [DN*DW-1:0] data;
        logic [DN-1:0]    keep;
        logic             last;
    } beat_t;

    state_t        state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] num_q, num_d;
    logic [LW-1:0] beat_q, beat_d;
    logic [LW-1:0] pkt_in_q, pkt_in_d;
    logic [LW-1:0] pkt_out_q, pkt_out_d;
    logic          rdy_q, rdy_d;
    beat_t         head_q, head_d, tail_q, tail_d;
    logic          head_vld_q, head_vld_d, tail_vld_q, tail_vld_d;

    logic  in_fire, in_last, out_fire, start_ok;
    beat_t in_beat;
    logic  unused_tlast;

    assign unused_tlast = s.TLAST;
    assign in_fire  = s.TVALID & rdy_q;
    assign in_last  = (beat_q == len_q);
    assign out_fire = head_vld_q & m.TREADY;
    assign start_ok = ctl_start & ~ctl_stop;
    assign in_beat  = '{data: s.TDATA, keep: s.TKEEP, last: in_last};

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        num_d     = num_q;
        beat_d    = beat_q;
        pkt_in_d  = pkt_in_q;
        pkt_out_d = pkt_out_q;

        if (in_fire) begin
            beat_d   = in_last ? '0 : beat_q + 1'b1;
            pkt_in_d = pkt_in_q + LW'(in_last);
        end
        if (out_fire && head_q.last)
            pkt_out_d = pkt_out_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d   = RUN;
                    len_d     = cfg_len;
                    num_d     = cfg_num;
                    beat_d    = '0;
                    pkt_in_d  = '0;
                    pkt_out_d = '0;
                end
            end
            RUN, STOP: begin
                if (in_fire && in_last &&
                    (state_q == STOP || (num_q != '0 && pkt_in_d == num_q)))
                    state_d = IDLE;
                // Boundary test uses the post-accept count so a beat taken
                // alongside the stop request is never orphaned without TLAST.
                else if (state_q == RUN && ctl_stop)
                    state_d = (beat_d == '0) ? IDLE : STOP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        head_vld_d = head_vld_q;
        tail_vld_d = tail_vld_q;

        if (out_fire) begin
            head_d     = tail_q;
            head_vld_d = tail_vld_q;
            tail_vld_d = 1'b0;
        end
        if (in_fire) begin
            if (!head_vld_d) begin
                head_d     = in_beat;
                head_vld_d = 1'b1;
            end else begin
                tail_d     = in_beat;
                tail_vld_d = 1'b1;
            end
        end
        // Entries stay compacted at the head, so a full buffer is just tail valid.
        rdy_d = (state_d != IDLE) & ~tail_vld_d;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= IDLE;
            len_q      <= '0;
            num_q      <= '0;
            beat_q     <= '0;
            pkt_in_q   <= '0;
            pkt_out_q  <= '0;
            rdy_q      <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            head_vld_q <= 1'b0;
            tail_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            num_q      <= num_d;
            beat_q     <= beat_d;
            pkt_in_q   <= pkt_in_d;
            pkt_out_q  <= pkt_out_d;
            rdy_q      <= rdy_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            head_vld_q <= head_vld_d;
            tail_vld_q <= tail_vld_d;
        end
    end

    assign s.TREADY = rdy_q;
    assign m.TDATA  = head_q.data;
    assign m.TKEEP  = head_q.keep;
    assign m.TLAST  = head_q.last;
    assign m.TVALID = head_vld_q;
    assign sts_busy = (state_q != IDLE) | head_vld_q;
    assign sts_pkt  = pkt_out_q;
endmodule

// File: tb/tb_axi4_stream_pkt.sv
// Bench for axi4_stream_pkt: random handshakes checked every cycle against a
// queue-based packet model built from the framing/run rules.
module tb_axi4_stream_pkt;
    localparam int DN = 1;
    localparam int DW = 8;
    localparam int LW = 16;

    logic ACLK = 1'b0;
    logic ARESET = 1'b1;
    always #5 ACLK = ~ACLK;

    axi4_stream_pkt_if #(.DN(DN), .DW(DW)) s_if ();
    axi4_stream_pkt_if #(.DN(DN), .DW(DW)) m_if ();

    logic [LW-1:0] cfg_len, cfg_num, sts_pkt;
    logic          ctl_start, ctl_stop, sts_busy;

    axi4_stream_pkt #(.DN(DN), .DW(DW), .LW(LW)) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .s         (s_if),
        .m         (m_if),
        .cfg_len   (cfg_len),
        .cfg_num   (cfg_num),
        .ctl_start (ctl_start),
        .ctl_stop  (ctl_stop),
        .sts_busy  (sts_busy),
        .sts_pkt   (sts_pkt)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       k;
        logic       l;
    } exp_t;

    exp_t q[$];
    bit   running, stopping, exp_rdy;
    int   beats, pkts_in, pkt_out, len_l, num_l;
    int   errors = 0, checks = 0;
    int   vp = 100, rp = 100, cyc = 0, n_in = 0, n_out = 0;
    bit   r13 = 0, seq = 0;
    logic [7:0] seq_d = 8'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        running = 0; stopping = 0; exp_rdy = 0;
        beats = 0; pkts_in = 0; pkt_out = 0;
    endtask

    task automatic step();
        bit in_f, out_f, last;
        s_if.TVALID  = ($urandom_range(99) < vp);
        s_if.TDATA   = seq ? seq_d : 8'($urandom);
        s_if.TKEEP   = 1'($urandom);
        m_if.TREADY  = r13 ? (cyc % 3 == 0) : ($urandom_range(99) < rp);
        @(negedge ACLK);
        chk("s_TREADY", s_if.TREADY, exp_rdy);
        chk("m_TVALID", m_if.TVALID, q.size() != 0);
        if (q.size() != 0) begin
            chk("m_TDATA", m_if.TDATA, q[0].d);
            chk("m_TKEEP", m_if.TKEEP, q[0].k);
            chk("m_TLAST", m_if.TLAST, q[0].l);
        end
        chk("sts_busy", sts_busy, running || q.size() != 0);
        chk("sts_pkt", sts_pkt, pkt_out);

        in_f  = s_if.TVALID && exp_rdy;
        out_f = (q.size() != 0) && m_if.TREADY;
        last  = 0;
        if (out_f) begin
            if (q[0].l) pkt_out++;
            void'(q.pop_front());
            n_out++;
        end
        if (in_f) begin
            last = (beats == len_l);
            q.push_back('{d: s_if.TDATA, k: s_if.TKEEP, l: last});
            n_in++;
            if (seq) seq_d++;
            if (last) begin beats = 0; pkts_in++; end
            else beats++;
        end
        if (!running) begin
            if (ctl_start && !ctl_stop) begin
                running = 1; stopping = 0;
                len_l = int'(cfg_len); num_l = int'(cfg_num);
                beats = 0; pkts_in = 0; pkt_out = 0;
            end
        end else if (in_f && last && (stopping || (num_l != 0 && pkts_in == num_l))) begin
            running = 0;
        end else if (ctl_stop && !stopping) begin
            if (beats == 0) running = 0;
            else stopping = 1;
        end
        exp_rdy = running && (q.size() < 2);
        @(posedge ACLK);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        ARESET = 1'b1; ctl_start = 1'b0; ctl_stop = 1'b0; s_if.TVALID = 1'b0;
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        model_clear();
        chk("rst_m_TVALID", m_if.TVALID, 0);
        chk("rst_m_TLAST", m_if.TLAST, 0);
        chk("rst_m_TDATA", m_if.TDATA, 0);
        chk("rst_m_TKEEP", m_if.TKEEP, 0);
        chk("rst_s_TREADY", s_if.TREADY, 0);
        chk("rst_sts_busy", sts_busy, 0);
        chk("rst_sts_pkt", sts_pkt, 0);
    endtask

    task automatic start_run(input int len, input int num);
        cfg_len = LW'(len); cfg_num = LW'(num);
        ctl_start = 1'b1;
        step();
        ctl_start = 1'b0;
    endtask

    task automatic run_until_idle(input string tag, input int maxc);
        int n = 0;
        while ((running || q.size() != 0) && n < maxc) begin
            step();
            n++;
        end
        chk({tag, "_timeout"}, (running || q.size() != 0), 0);
    endtask

    initial begin
        int g;
        int snap;
        cfg_len = '0; cfg_num = '0; ctl_start = 1'b0; ctl_stop = 1'b0;
        s_if.TVALID = 1'b0; s_if.TDATA = '0; s_if.TKEEP = '0; s_if.TLAST = 1'b0;
        m_if.TREADY = 1'b1;
        do_reset();

        // Basic framing: 2 packets of 4, data 0..7
        seq = 1; seq_d = 8'd0; n_out = 0;
        start_run(3, 2);
        run_until_idle("basic", 100);
        chk("basic_beats_out", n_out, 8);
        chk("basic_sts_pkt", sts_pkt, 2);
        seq = 0;
        repeat (3) step();

        // Back-pressure: ready 1-in-3
        r13 = 1; n_out = 0;
        start_run(4, 3);
        run_until_idle("bp", 400);
        chk("bp_beats_out", n_out, 15);
        r13 = 0;

        // Stop mid-packet
        n_in = 0; g = 0;
        start_run(7, 0);
        while (n_in < 3 && g < 50) begin step(); g++; end
        ctl_stop = 1'b1; step(); ctl_stop = 1'b0;
        run_until_idle("stopmid", 100);
        chk("stopmid_beats_in", n_in, 8);
        chk("stopmid_sts_pkt", sts_pkt, 1);

        // Stop at a packet boundary, with output held so busy lingers
        n_in = 0; g = 0;
        start_run(2, 0);
        while (n_in < 3 && g < 50) begin step(); g++; end
        vp = 0; rp = 0;
        ctl_stop = 1'b1; step(); ctl_stop = 1'b0;
        snap = n_in;
        repeat (3) step();
        vp = 100;
        repeat (2) step();
        rp = 100;
        run_until_idle("stopbnd", 50);
        chk("stopbnd_beats_in", n_in, snap);
        chk("stopbnd_busy", sts_busy, 0);

        // cfg_len = 0: every beat carries TLAST
        vp = 60; rp = 70; n_out = 0;
        start_run(0, 5);
        run_until_idle("len0", 200);
        chk("len0_beats_out", n_out, 5);

        // start+stop together in IDLE does nothing
        cfg_len = LW'(2); ctl_start = 1'b1; ctl_stop = 1'b1;
        step();
        ctl_start = 1'b0; ctl_stop = 1'b0;
        repeat (4) step();
        chk("ss_idle_busy", sts_busy, 0);

        // start and config change during a run are ignored
        n_out = 0;
        start_run(1, 3);
        repeat (3) step();
        cfg_len = LW'(5); cfg_num = LW'(1); ctl_start = 1'b1;
        step();
        ctl_start = 1'b0;
        run_until_idle("midcfg", 200);
        chk("midcfg_beats_out", n_out, 6);

        // Random runs with optional stop
        for (int r = 0; r < 6; r++) begin
            vp = $urandom_range(30, 100);
            rp = $urandom_range(30, 100);
            start_run($urandom_range(0, 5), $urandom_range(1, 4));
            repeat ($urandom_range(0, 12)) step();
            if ($urandom_range(1) == 1) begin
                ctl_stop = 1'b1; step(); ctl_stop = 1'b0;
            end
            run_until_idle("rand", 500);
        end

        // Reset with two beats buffered
        vp = 100; rp = 0;
        start_run(7, 0);
        repeat (4) step();
        chk("rstmid_full_rdy", s_if.TREADY, 0);
        chk("rstmid_full_vld", m_if.TVALID, 1);
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
